// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional watchdog abort of stuck frames is enabled with `define UART_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDW            = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                 CLK_i,
  input  logic                 RST_i,
  input  logic [NUM_REQ-1:0]   REQ_i,
  input  logic [8*NUM_REQ-1:0] DATA_i,
  output logic [NUM_REQ-1:0]   ACK_o,
  output logic [NUM_REQ-1:0]   DONE_o,
  output logic                 BUSY_o,
  output logic [IDW-1:0]       OWNER_o,
  output logic                 UART_TRANSMIT_o,
  output logic [7:0]           UART_TX_BYTE_o,
  input  logic                 UART_IS_TRANSMITTING_i
`ifdef UART_TIMEOUT_EN
  ,
  output logic                 TIMEOUT_o
`endif
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] LAUNCH     = 2'd1;
  localparam logic [1:0] WAIT_START = 2'd2;
  localparam logic [1:0] WAIT_DONE  = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic           found;
  logic [IDW-1:0] win;
  logic [IDW-1:0] win_next;
  logic [IDW:0]   cand;
  logic           in_wait;
  logic           timed_out;
  logic           abort;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NUM_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Search upward from the round-robin pointer, wrapping at NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NUM_REQ))
        cand = cand - (IDW+1)'(NUM_REQ);
      if (!found && REQ_i[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  assign win_next = (win == IDW'(NUM_REQ-1)) ? '0 : win + 1'b1;
  assign in_wait  = (state == WAIT_START) || (state == WAIT_DONE);
  assign abort    = in_wait && timed_out;

`ifdef UART_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt;

  assign timed_out = (tcnt == TW'(TIMEOUT_CYCLES-1));

  // Counter restarts when the strobe is issued and runs through both wait states.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      tcnt      <= '0;
      TIMEOUT_o <= 1'b0;
    end else begin
      TIMEOUT_o <= abort;
      if (state == LAUNCH)
        tcnt <= '0;
      else if (in_wait)
        tcnt <= tcnt + 1'b1;
    end
  end
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      ACK_o           <= '0;
      DONE_o          <= '0;
      BUSY_o          <= 1'b0;
      OWNER_o         <= '0;
      UART_TRANSMIT_o <= 1'b0;
      UART_TX_BYTE_o  <= '0;
    end else begin
      ACK_o           <= '0;
      DONE_o          <= '0;
      UART_TRANSMIT_o <= 1'b0;
      case (state)
        IDLE: begin
          // Foreign traffic on the UART blocks any new grant.
          if (found && !UART_IS_TRANSMITTING_i) begin
            UART_TX_BYTE_o <= DATA_i[{win, 3'b000} +: 8];
            OWNER_o        <= win;
            ACK_o          <= onehot(win);
            rr_ptr         <= win_next;
            BUSY_o         <= 1'b1;
            state          <= LAUNCH;
          end
        end
        LAUNCH: begin
          UART_TRANSMIT_o <= 1'b1;
          state           <= WAIT_START;
        end
        WAIT_START: begin
          if (abort) begin
            BUSY_o <= 1'b0;
            state  <= IDLE;
          end else if (UART_IS_TRANSMITTING_i) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (abort) begin
            BUSY_o <= 1'b0;
            state  <= IDLE;
          end else if (!UART_IS_TRANSMITTING_i) begin
            DONE_o <= onehot(OWNER_o);
            BUSY_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          BUSY_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy-flag model.
// Timeout scenario is compiled in when UART_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int LIM = 5000;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic        busy_o;
  logic [1:0]  owner;
  logic        tx_strobe;
  logic [7:0]  tx_byte;
  logic        uart_busy;
  logic        foreign;
  logic        model_en;
  int          hold;
  int          mcnt;
  int          n_tests;
  int          n_fail;
`ifdef UART_TIMEOUT_EN
  logic        timeout;
`endif

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .CLK_i                  (clk),
    .RST_i                  (rst),
    .REQ_i                  (req),
    .DATA_i                 (data),
    .ACK_o                  (ack),
    .DONE_o                 (done),
    .BUSY_o                 (busy_o),
    .OWNER_o                (owner),
    .UART_TRANSMIT_o        (tx_strobe),
    .UART_TX_BYTE_o         (tx_byte),
    .UART_IS_TRANSMITTING_i (uart_busy)
`ifdef UART_TIMEOUT_EN
    ,
    .TIMEOUT_o              (timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model: busy rises the cycle after the strobe and lasts 'hold' cycles.
  always @(posedge clk or posedge rst) begin
    if (rst)
      mcnt <= 0;
    else if (tx_strobe && model_en)
      mcnt <= hold;
    else if (mcnt != 0)
      mcnt <= mcnt - 1;
  end
  assign uart_busy = (mcnt != 0) || foreign;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int k, input logic [7:0] b);
    int c;
    c = 0;
    while (ack === 4'b0000 && c < LIM) begin
      @(negedge clk);
      c++;
    end
    check("ack", ack, 4'b0001 << k);
    @(negedge clk);
    check("strobe", tx_strobe, 1);
    check("tx_byte", tx_byte, b);
    check("owner", owner, k);
    check("ack_pulse", ack, 0);
    @(negedge clk);
    check("strobe_pulse", tx_strobe, 0);
  endtask

  task automatic wait_done(input int k);
    int c;
    c = 0;
    while (done === 4'b0000 && c < LIM) begin
      @(negedge clk);
      c++;
    end
    check("done", done, 4'b0001 << k);
    check("busy_at_done", busy_o, 0);
  endtask

  task automatic wait_uart(input logic lvl);
    int c;
    c = 0;
    while (uart_busy !== lvl && c < LIM) begin
      @(negedge clk);
      c++;
    end
    check("uart_wait", uart_busy, lvl);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = '0;
    data     = '0;
    foreign  = 1'b0;
    model_en = 1'b1;
    hold     = 3120;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy_o, 0);
    check("rst_owner", owner, 0);
    check("rst_strobe", tx_strobe, 0);
    check("rst_byte", tx_byte, 0);
    rst = 1'b0;

    // Single request with exact latency
    data[23:16] = 8'hA5;
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    check("s_ack", ack, 4'b0100);
    check("s_busy", busy_o, 1);
    req = 4'b0000;
    @(negedge clk);
    check("s_strobe", tx_strobe, 1);
    check("s_byte", tx_byte, 8'hA5);
    check("s_owner", owner, 2);
    @(negedge clk);
    check("s_strobe_off", tx_strobe, 0);
    wait_uart(1'b1);
    wait_uart(1'b0);
    check("s_done_early", done, 0);
    check("s_busy_hold", busy_o, 1);
    check("s_byte_hold", tx_byte, 8'hA5);
    @(negedge clk);
    check("s_done", done, 4'b0100);
    check("s_busy_drop", busy_o, 0);
    @(negedge clk);
    check("s_done_pulse", done, 0);

    // Round robin with all requesters active
    hold = 20;
    do_reset();
    data = 32'h13121110;
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(i % 4, 8'h10 + 8'(i % 4));
      wait_done(i % 4);
    end
    req = 4'b0000;

    // Pointer wrap
    do_reset();
    req = 4'b1000;
    wait_grant(3, 8'h13);
    req = 4'b1001;
    wait_done(3);
    wait_grant(0, 8'h10);
    wait_done(0);
    wait_grant(3, 8'h13);
    req = 4'b0000;
    wait_done(3);

    // Foreign busy blocks the grant
    do_reset();
    foreign = 1'b1;
    req     = 4'b0001;
    repeat (6) begin
      @(negedge clk);
      check("f_no_ack", ack, 0);
    end
    foreign = 1'b0;
    wait_grant(0, 8'h10);
    req = 4'b0000;
    wait_done(0);

    // Withdrawal before ACK
    foreign = 1'b1;
    req     = 4'b0010;
    repeat (3) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    foreign = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("w_no_ack", ack, 0);
      check("w_no_strobe", tx_strobe, 0);
    end

    // Async reset while waiting for the frame to finish
    req = 4'b0100;
    wait_grant(2, 8'h12);
    req = 4'b0000;
    repeat (10) @(negedge clk);
    check("a_busy_pre", busy_o, 1);
    #3 rst = 1'b1;
    #1;
    check("a_ack", ack, 0);
    check("a_done", done, 0);
    check("a_busy", busy_o, 0);
    check("a_owner", owner, 0);
    check("a_strobe", tx_strobe, 0);
    check("a_byte", tx_byte, 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1001;
    wait_grant(0, 8'h10);
    req = 4'b0000;
    wait_done(0);

`ifdef UART_TIMEOUT_EN
    // UART never responds; watchdog aborts and the next requester is served
    model_en = 1'b0;
    req      = 4'b0001;
    wait_grant(0, 8'h10);
    req = 4'b0010;
    repeat (14) begin
      @(negedge clk);
      check("t_early", timeout, 0);
      check("t_no_done", done, 0);
    end
    @(negedge clk);
    check("t_pulse", timeout, 1);
    check("t_no_done_end", done, 0);
    check("t_busy", busy_o, 0);
    model_en = 1'b1;
    wait_grant(1, 8'h11);
    check("t_pulse_off", timeout, 0);
    req = 4'b0000;
    wait_done(1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte sources using round-robin arbitration.
- Latches the winning byte and pulses the UART transmit strobe. Tracks the UART busy flag through the whole frame, then reports completion to the owner.
- Sits between application producers (status reporters, loopback echo, debug dump) and the uart instance's transmit, tx_byte and is_transmitting pins.

Parameters:
- NUM_REQ, 4: number of requesters, legal range 2..8.
- IDW, $clog2(NUM_REQ): width of OWNER_o; derived, never overridden.
- TIMEOUT_CYCLES, 8192: watchdog limit in clocks. Used only when UART_TIMEOUT_EN is defined.

Ports:
- CLK_i  input  1  master clock.
- RST_i  input  1  reset; asynchronous, active-high.
- REQ_i  input  NUM_REQ  per-requester send request, level.
- DATA_i  input  8*NUM_REQ  packed bytes; requester k uses bits [8k+7:8k].
- ACK_o  output  NUM_REQ  one-cycle pulse: requester's byte latched.
- DONE_o  output  NUM_REQ  one-cycle pulse: requester's frame fully sent.
- BUSY_o  output  1  high whenever state is not IDLE.
- OWNER_o  output  IDW  index of current or last granted requester.
- UART_TRANSMIT_o  output  1  transmit strobe to uart.
- UART_TX_BYTE_o  output  8  byte to uart; held stable from ACK until DONE.
- UART_IS_TRANSMITTING_i  input  1  uart busy flag.
- TIMEOUT_o  output  1  one-cycle abort pulse; port exists only with UART_TIMEOUT_EN.

Behaviour:
- Reset (async, any state): state=IDLE, rr pointer=0. All outputs are 0: ACK_o, DONE_o, BUSY_o, OWNER_o, UART_TRANSMIT_o, UART_TX_BYTE_o.
- FSM states: IDLE, LAUNCH, WAIT_START, WAIT_DONE. All outputs are registered.
- IDLE:
  - Grant condition: REQ_i!=0 and UART_IS_TRANSMITTING_i=0.
  - Winner k is the first set REQ_i bit searching upward from the rr pointer, wrapping at NUM_REQ-1 to 0.
  - On the next edge: UART_TX_BYTE_o<=DATA_i[k]; OWNER_o<=k; ACK_o[k]=1 for one cycle; rr pointer<=(k+1) mod NUM_REQ; go LAUNCH.
  - If UART_IS_TRANSMITTING_i=1 (foreign activity), no grant is made.
- LAUNCH: UART_TRANSMIT_o=1 for exactly this one cycle; go WAIT_START.
- WAIT_START: wait for UART_IS_TRANSMITTING_i=1, then go WAIT_DONE.
- WAIT_DONE: on UART_IS_TRANSMITTING_i=0, DONE_o[OWNER_o]=1 for one cycle; go IDLE.
- Latency, REQ seen in IDLE at cycle n:
  - ACK_o at n+1.
  - UART_TRANSMIT_o at n+2.
  - Earliest next grant is the cycle after DONE_o.
- Requester rules:
  - Hold REQ_i and the DATA byte until ACK.
  - Deasserting REQ_i before ACK withdraws the request, with no side effects.
  - REQ_i still high on the cycle after ACK counts as a new request for the next byte.
- Fairness: with all requesters continuously requesting, grants go 0,1,2,...,NUM_REQ-1,0. Each requester waits at most NUM_REQ-1 other frames.
- REQ_i changes while not IDLE are ignored until IDLE.
- ACK_o and DONE_o are one-hot or zero; never more than one bit set.

Optional Feature:
- Macro: UART_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_START and increments each cycle in WAIT_START and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE, pulses TIMEOUT_o for one cycle, and emits no DONE_o.
  - The rr pointer keeps its already-advanced value.
- Undefined: no counter and no TIMEOUT_o port; WAIT_START and WAIT_DONE wait indefinitely.

Test Plan:
- Single request:
  - Stimulus: reset; REQ_i=4'b0100, DATA_i[23:16]=8'hA5; bench UART model raises busy 1 cycle after the strobe and holds it 3120 cycles.
  - Required response: ACK_o=4'b0100 at n+1; UART_TRANSMIT_o single pulse at n+2 with UART_TX_BYTE_o=8'hA5; OWNER_o=2; DONE_o=4'b0100 one cycle after busy falls; BUSY_o then drops.
- Round robin:
  - Stimulus: REQ_i=4'b1111 held, bytes 8'h10,8'h11,8'h12,8'h13.
  - Required response: ACK order 0,1,2,3,0; transmitted bytes 10,11,12,13,10.
- Pointer wrap:
  - Stimulus: after granting 3, REQ_i=4'b1001.
  - Required response: next grant goes to 0, then 3.
- Foreign busy and withdrawal:
  - Stimulus: UART_IS_TRANSMITTING_i=1 while IDLE with REQ_i=4'b0001.
  - Required response: no ACK until busy falls.
  - Stimulus: drop REQ before ACK.
  - Required response: no ACK, no strobe.
- Async reset in WAIT_DONE:
  - Stimulus: assert RST_i mid-cycle.
  - Required response: all outputs 0 immediately; next grant starts from requester 0.
- UART_TIMEOUT_EN, TIMEOUT_CYCLES=16:
  - Stimulus: UART model never raises busy.
  - Required response: TIMEOUT_o pulse 16 cycles after entering WAIT_START; no DONE_o; state returns to IDLE and the next requester is served.
